// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 rotating-priority select block:
// channel geometry, FSM state encoding and a one-hot helper.
package lab5_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_CH-1:0] chan_onehot(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/lab5_rr_pick.sv
// Combinational rotating-priority search: first set request bit starting
// one channel after the most recently granted one, wrapping around.
module lab5_rr_pick
    import lab5_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [SEL_W-1:0]    start;
    logic [2*NUM_CH-2:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W-1:0]    offs;

    // Rotate requests so bit 0 is the highest-priority channel, then priority-encode.
    always_comb begin
        start = last + 2'd1;
        dbl   = {req[NUM_CH-2:0], req};
        rot   = dbl[start +: NUM_CH];
        any   = 1'b1;
        offs  = 2'd0;
        casez (rot)
            4'b???1: offs = 2'd0;
            4'b??10: offs = 2'd1;
            4'b?100: offs = 2'd2;
            4'b1000: offs = 2'd3;
            default: begin
                offs = 2'd0;
                any  = 1'b0;
            end
        endcase
        idx = start + offs;
    end

endmodule

// File: rtl/lab5_rr_select.sv
// Round-robin grant controller driving the select of a 4-to-1 mux.
// A grant lasts until release, its request drops, or HOLD_MAX cycles elapse.
module lab5_rr_select
    import lab5_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              release_in,
    output logic [SEL_W-1:0]  S,
    output logic              grant_valid,
    output logic [NUM_CH-1:0] grant
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic              grant_valid_q, grant_valid_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    lab5_rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        last_d        = last_q;
        grant_valid_d = grant_valid_q;
        grant_d       = grant_q;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d       = GRANT;
                    s_d           = pick_idx;
                    grant_valid_d = 1'b1;
                    grant_d       = chan_onehot(pick_idx);
                    hold_cnt_d    = 8'd0;
                end else begin
                    grant_valid_d = 1'b0;
                    grant_d       = 4'b0000;
                end
            end
            GRANT: begin
                // Any exit cause, alone or combined, takes the same single path back to IDLE.
                if (release_in || !req[s_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d       = IDLE;
                    last_d        = s_q;
                    grant_valid_d = 1'b0;
                    grant_d       = 4'b0000;
                    hold_cnt_d    = 8'd0;
                end else if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                grant_d       = 4'b0000;
                hold_cnt_d    = 8'd0;
            end
        endcase
    end

    // State register with synchronous reset; last starts at 3 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            s_q           <= 2'b00;
            last_q        <= 2'b11;
            grant_valid_q <= 1'b0;
            grant_q       <= 4'b0000;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            last_q        <= last_d;
            grant_valid_q <= grant_valid_d;
            grant_q       <= grant_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign S           = s_q;
    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_lab5_rr_select.sv
// Bench for lab5_rr_select: a behavioural arbiter model checked every cycle
// against two instances (HOLD_MAX=8 and HOLD_MAX=1), plus directed literal checks.
module tb_lab5_rr_select;

    logic       clk = 1'b0;
    logic       reset;
    logic       release_in;
    logic [3:0] req;
    logic [1:0] s8, s1;
    logic       gv8, gv1;
    logic [3:0] g8, g1;
    logic       y8;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int run1 = 0;
    int max1 = 0;
    int n;
    int guard;

    logic [1:0] exp_s [5];
    logic [3:0] exp_g [5];
    logic [3:0] tab_req [13];
    logic       tab_rel [13];

    typedef struct packed {
        logic       busy;
        logic [1:0] cur;
        logic [1:0] last;
        logic [7:0] held;
    } mdl_t;

    mdl_t m8 = {1'b0, 2'd0, 2'd3, 8'd0};
    mdl_t m1 = {1'b0, 2'd0, 2'd3, 8'd0};

    always #5 clk = ~clk;

    lab5_rr_select #(.HOLD_MAX(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .release_in  (release_in),
        .S           (s8),
        .grant_valid (gv8),
        .grant       (g8)
    );

    lab5_rr_select #(.HOLD_MAX(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .release_in  (release_in),
        .S           (s1),
        .grant_valid (gv1),
        .grant       (g1)
    );

    // Reference 4-to-1 mux with D = req, selected by the DUT's S.
    assign y8 = req[s8];

    function automatic mdl_t mdl_next(input mdl_t m, input logic [3:0] r, input logic rl,
                                      input logic rs, input int hmax);
        mdl_t nx;
        nx = m;
        if (rs) begin
            nx.busy = 1'b0;
            nx.cur  = 2'd0;
            nx.last = 2'd3;
            nx.held = 8'd0;
        end else if (m.busy) begin
            if (rl || !r[m.cur] || (int'(m.held) + 1 >= hmax)) begin
                nx.busy = 1'b0;
                nx.last = m.cur;
                nx.held = 8'd0;
            end else begin
                nx.held = m.held + 8'd1;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (int'(m.last) + k) % 4;
                if (!nx.busy && r[c]) begin
                    nx.busy = 1'b1;
                    nx.cur  = c[1:0];
                    nx.held = 8'd0;
                end
            end
        end
        return nx;
    endfunction

    function automatic logic [3:0] mdl_grant(input mdl_t m);
        return m.busy ? (4'b0001 << m.cur) : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rl, input logic rs);
        req        = r;
        release_in = rl;
        reset      = rs;
        @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        m8 <= mdl_next(m8, req, release_in, reset, 8);
        m1 <= mdl_next(m1, req, release_in, reset, 1);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("h8_S", 32'(s8), 32'(m8.cur));
            check("h8_grant_valid", 32'(gv8), 32'(m8.busy));
            check("h8_grant", 32'(g8), 32'(mdl_grant(m8)));
            check("h1_S", 32'(s1), 32'(m1.cur));
            check("h1_grant_valid", 32'(gv1), 32'(m1.busy));
            check("h1_grant", 32'(g1), 32'(mdl_grant(m1)));
            if (gv8 && !release_in) check("mux_y", 32'(y8), 32'd1);
            if (gv1) begin
                run1 <= run1 + 1;
                if (run1 + 1 > max1) max1 <= run1 + 1;
            end else begin
                run1 <= 0;
            end
        end
    end

    initial begin
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tab_req = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b1111, 4'b0011,
                    4'b0010, 4'b1111, 4'b1111, 4'b0000, 4'b1001, 4'b1001};
        tab_rel = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset held two cycles with all requests active.
        step(4'b1111, 1'b0, 1'b1);
        chk_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_S", 32'(s8), 32'd0);
            check("rst_grant_valid", 32'(gv8), 32'd0);
            check("rst_grant", 32'(g8), 32'd0);
            if (i == 0) step(4'b1111, 1'b0, 1'b1);
        end

        // Round-robin with a release one cycle after each grant.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0);
            check("rr_grant_valid", 32'(gv8), 32'd1);
            check("rr_S", 32'(s8), 32'(exp_s[i]));
            check("rr_grant", 32'(g8), 32'(exp_g[i]));
            step(4'b1111, 1'b1, 1'b0);
            check("rr_idle_gap", 32'(gv8), 32'd0);
        end

        // Single requester held: forced rotation after 8 cycles, then regrant.
        step(4'b0100, 1'b0, 1'b0);
        n = 0;
        guard = 0;
        while (gv8 && guard < 20) begin
            check("hold_S", 32'(s8), 32'd2);
            n++;
            guard++;
            step(4'b0100, 1'b0, 1'b0);
        end
        check("hold_len", 32'(n), 32'd8);
        check("hold_gap_S", 32'(s8), 32'd2);
        step(4'b0100, 1'b0, 1'b0);
        check("regrant_valid", 32'(gv8), 32'd1);
        check("regrant_S", 32'(s8), 32'd2);
        step(4'b0000, 1'b1, 1'b0);

        // Drop req[1] and release together: one exit, then ch0 wins from last=1.
        step(4'b0010, 1'b0, 1'b0);
        check("ch1_S", 32'(s8), 32'd1);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("dual_exit_valid", 32'(gv8), 32'd0);
        check("dual_exit_S", 32'(s8), 32'd1);
        step(4'b0011, 1'b0, 1'b0);
        check("after_dual_S", 32'(s8), 32'd0);
        check("after_dual_valid", 32'(gv8), 32'd1);
        step(4'b0011, 1'b1, 1'b0);

        // Reset on the third GRANT cycle of ch3.
        step(4'b1000, 1'b0, 1'b0);
        check("ch3_S", 32'(s8), 32'd3);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1);
        check("midrst_valid", 32'(gv8), 32'd0);
        check("midrst_S", 32'(s8), 32'd0);
        step(4'b1000, 1'b0, 1'b0);
        check("postrst_valid", 32'(gv8), 32'd1);
        check("postrst_S", 32'(s8), 32'd3);
        step(4'b0000, 1'b1, 1'b0);

        // Mixed vectors, including other requests changing mid-grant.
        for (int i = 0; i < 13; i++) step(tab_req[i], tab_rel[i], 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("h1_max_grant_len", 32'(max1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab5_rr_select.md
LAB5_RR_SELECT -- requirements
Module: lab5_rr_select

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one grant is held before forced rotation (range 1..255).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: req  input  4  request bit per data channel D0..D3 (bit i = channel i).
REQ-005 Port: release  input  1  holder of current grant relinquishes it this cycle.
REQ-006 Port: S  output  2  registered channel index; drives select of downstream 1-bit 4-to-1 mux.
REQ-007 Port: grant_valid  output  1  high while S names a granted channel.
REQ-008 Port: grant  output  4  registered one-hot of S when grant_valid=1, else 4'b0000.

Function
REQ-009 FSM SHALL have two states: IDLE, GRANT; all outputs registered, no combinational input-to-output path.
REQ-010 Internal pointer last (2 bits) SHALL hold the index of the most recently granted channel.
REQ-011 In IDLE with req != 0, block SHALL select first set req bit searching (last+1), (last+2), (last+3), (last+4) mod 4, and on the next edge enter GRANT with S=selected index, grant_valid=1, grant=one-hot, hold_cnt=0.
REQ-012 In IDLE with req == 0, state, S, last SHALL be unchanged; grant_valid=0, grant=0.
REQ-013 In GRANT, hold_cnt SHALL increment by 1 each cycle, saturating at HOLD_MAX-1.
REQ-014 GRANT SHALL exit to IDLE on the next edge when any of: release=1, req[S]=0, hold_cnt==HOLD_MAX-1.
REQ-015 On GRANT exit: last<=S, grant_valid<=0, grant<=0, hold_cnt<=0; S SHALL retain its value.
REQ-016 Simultaneous exit conditions SHALL produce exactly one exit, with identical behaviour.
REQ-017 Every grant SHALL be followed by at least one IDLE cycle (grant_valid low for >=1 cycle between grants).
REQ-018 A channel whose req stays high SHALL be granted within 4 grant periods (no starvation).
REQ-019 Changes on req bits other than req[S] during GRANT SHALL not affect the current grant.
REQ-020 HOLD_MAX=1 SHALL yield grants exactly one cycle long.

Reset
REQ-021 On reset=1 at a clk edge: state=IDLE, S=2'b00, grant_valid=0, grant=4'b0000, hold_cnt=0, last=2'b11 (channel 0 highest priority first).
REQ-022 Reset SHALL override every other input, including mid-GRANT; the first grant after reset follows REQ-011.

Structure
REQ-023 Shared package lab5_pkg SHALL hold: state encoding (IDLE, GRANT), channel count constant 4, select width constant 2.
REQ-024 Rotating-priority search SHALL be a separate combinational sub-module lab5_rr_pick (inputs req[3:0], last[1:0]; outputs idx[1:0], any).
REQ-025 Top SHALL be directly connectable: S of lab5_rr_select to S of the 4-to-1 mux, no glue logic.

Verification
REQ-026 Reset asserted 2 cycles with req=4'b1111 -> S=00, grant_valid=0, grant=0000 throughout reset.
REQ-027 After reset, req=4'b1111, release pulsed 1 cycle after each grant -> grant sequence ch0, ch1, ch2, ch3, ch0, one IDLE cycle between each.
REQ-028 HOLD_MAX=8, req=4'b0100 held, release=0 -> grant_valid high exactly 8 cycles with S=10, 1 cycle low, then regrant ch2.
REQ-029 During GRANT of ch1, drop req[1] and raise release same cycle -> single exit, last=01; next grant with req=4'b0011 goes to ch0.
REQ-030 Reset asserted on 3rd cycle of GRANT of ch3 -> next cycle grant_valid=0, S=00; with req=4'b1000 first grant is ch3 after 1 IDLE cycle.
REQ-031 Self-checking bench: 2-bit S feeds reference 4-to-1 mux with D=req; check Y=1 whenever grant_valid=1; report error count at end.
